// File: rtl/ck_ce_pkg.sv
// Shared constants for the clock-enable generator.
package ck_ce_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Source-select encoding for sel_ext.
  localparam logic SRC_INT = 1'b0;
  localparam logic SRC_EXT = 1'b1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on rst.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Plain two-stage capture; the first flop may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ck_ce_gen.sv
// Regenerated clock level plus rise/fall clock-enable pulses, sourced either from
// an internal half-period divider or from a synchronized external clock.
module ck_ce_gen
  import ck_ce_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel_ext,
  input  logic [DIV_W-1:0] div,
  input  logic             ext_ck,
  output logic             ck_out,
  output logic             ce_rise,
  output logic             ce_fall,
  output logic [CNT_W-1:0] rise_cnt
);

  logic             ext_s;     // synchronized ext_ck level
  logic             sel_q;     // previous-cycle source select
  logic             sw;        // source changed this cycle
  logic             tgl;       // ck_out changes at the next edge
  logic             ck_nxt;
  logic [DIV_W-1:0] cnt;       // phase counter (internal mode)
  logic [DIV_W-1:0] cnt_nxt;

  // The synchronizer runs regardless of en so the level is current when en returns.
  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_ck),
    .q   (ext_s)
  );

  // Next-state selection: a source switch freezes the output for one cycle, en=0
  // freezes everything, otherwise the selected source decides whether to toggle.
  always_comb begin
    sw      = (sel_ext != sel_q);
    tgl     = 1'b0;
    ck_nxt  = ck_out;
    cnt_nxt = cnt;
    if (sw) begin
      cnt_nxt = '0;
    end else if (en) begin
      if (sel_ext == SRC_EXT) begin
        cnt_nxt = '0;
        if (ext_s != ck_out) begin
          tgl    = 1'b1;
          ck_nxt = ext_s;
        end
      end else if (cnt >= div) begin
        // >= so that lowering div below the running count toggles immediately.
        tgl     = 1'b1;
        ck_nxt  = ~ck_out;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Register level, pulses and counter together so pulses line up with ck_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= SRC_INT;
      cnt      <= '0;
      ck_out   <= 1'b0;
      ce_rise  <= 1'b0;
      ce_fall  <= 1'b0;
      rise_cnt <= '0;
    end else begin
      sel_q   <= sel_ext;
      cnt     <= cnt_nxt;
      ck_out  <= ck_nxt;
      ce_rise <= tgl & ck_nxt;
      ce_fall <= tgl & ~ck_nxt;
      if (tgl && ck_nxt)
        rise_cnt <= rise_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ck_ce_gen.sv
// Directed bench for ck_ce_gen: a vector table for the basic divider behaviour
// followed by hand-written multi-cycle sequences.
module tb_ck_ce_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sel_ext = 1'b0;
  logic [7:0] div = 8'd1;
  logic       ext_ck = 1'b0;
  logic       ck_out, ce_rise, ce_fall;
  logic [3:0] rise_cnt;

  int errors = 0;
  int checks = 0;
  logic [3:0] ec;

  ck_ce_gen #(.DIV_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sel_ext  (sel_ext),
    .div      (div),
    .ext_ck   (ext_ck),
    .ck_out   (ck_out),
    .ce_rise  (ce_rise),
    .ce_fall  (ce_fall),
    .rise_cnt (rise_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, sel;
    logic [7:0] div;
    logic       ck, r, f;
    logic [3:0] c;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic ck, input logic r,
                     input logic f, input logic [3:0] c);
    checks++;
    if ({ck_out, ce_rise, ce_fall, rise_cnt} !== {ck, r, f, c}) begin
      errors++;
      $display("FAIL %s[%0d]: got ck=%b rise=%b fall=%b cnt=%0d, want ck=%b rise=%b fall=%b cnt=%0d",
               nm, idx, ck_out, ce_rise, ce_fall, rise_cnt, ck, r, f, c);
    end
    checks++;
    if (ce_rise && ce_fall) begin
      errors++;
      $display("FAIL %s[%0d] overlap: got rise=1 fall=1, want at most one", nm, idx);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ec  = '0;
  endtask

  initial begin
    // rst, en, sel, div | ck, rise, fall, cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 4'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 4'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd3};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd3};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 4'd4};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; sel_ext = tbl[i].sel; div = tbl[i].div;
      step();
      chk("tbl", i, tbl[i].ck, tbl[i].r, tbl[i].f, tbl[i].c);
    end

    // div=2: period 6, rise at cycle 3, fall 3 cycles later, 4 rises in 24 cycles.
    en = 1'b1; sel_ext = 1'b0; div = 8'd2;
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i % 6 == 3) ec++;
      chk("div2", i, (i % 6) >= 3, (i % 6) == 3, (i % 6) == 0, ec);
    end
    checks++;
    if (rise_cnt !== 4'd4) begin
      errors++;
      $display("FAIL div2_cnt24: got %0d want 4", rise_cnt);
    end

    // Lower div below the running count: toggle next cycle, then period 8.
    div = 8'd10;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("div10", i, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    div = 8'd3;
    step();
    chk("div_drop", 0, 1'b1, 1'b1, 1'b0, 4'd1);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("div3", j, (j < 4) || (j == 8), j == 8, j == 4, (j == 8) ? 4'd2 : 4'd1);
    end

    // div=0 toggling until the 4-bit rise counter wraps.
    div = 8'd0;
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      step();
      if (i % 2 == 1) ec++;
      chk("div0", i, (i % 2) == 1, (i % 2) == 1, (i % 2) == 0, ec);
      if (i == 29 || i == 31) begin
        checks++;
        if (rise_cnt !== ((i == 29) ? 4'd15 : 4'd0)) begin
          errors++;
          $display("FAIL wrap[%0d]: got %0d want %0d", i, rise_cnt, (i == 29) ? 15 : 0);
        end
      end
    end

    // Reset mid-period: partial count discarded, first rise div+1 cycles later.
    div = 8'd3;
    do_reset();
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_mid", 0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("rst_after", j, j == 4, j == 4, 1'b0, (j == 4) ? 4'd1 : 4'd0);
    end

    // External mode: 20-cycle square wave, pulses 3 cycles after each ext edge.
    sel_ext = 1'b1; ext_ck = 1'b0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("ext_settle", j, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    for (int i = 0; i < 90; i++) begin
      ext_ck = (i % 20) < 10;
      en     = !(i >= 40 && i < 70);
      step();
      if (!en) begin
        chk("ext_en0", i, 1'b0, 1'b0, 1'b0, ec);
      end else begin
        if ((i % 20) == 2 || i == 70) ec++;
        chk("ext", i, ((i + 18) % 20) < 10, ((i % 20) == 2) || (i == 70), (i % 20) == 12, ec);
      end
    end

    // Source switch mid-period: no pulse and held level in the switch cycle.
    sel_ext = 1'b0; ext_ck = 1'b1; div = 8'd5; en = 1'b1;
    do_reset();
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("sw_int", j, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    sel_ext = 1'b1;
    step();
    chk("sw_to_ext", 0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("sw_ext", 1, 1'b1, 1'b1, 1'b0, 4'd1);
    step();
    chk("sw_ext", 2, 1'b1, 1'b0, 1'b0, 4'd1);
    sel_ext = 1'b0; div = 8'd0;
    step();
    chk("sw_to_int", 0, 1'b1, 1'b0, 1'b0, 4'd1);
    step();
    chk("sw_int2", 1, 1'b0, 1'b0, 1'b1, 4'd1);
    step();
    chk("sw_int2", 2, 1'b1, 1'b1, 1'b0, 4'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
